// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that processes CHUNK bits per
// clock, LSB slice first, with a registered carry between slices.
//
// Handshake: start is sampled on a rising edge while the block is not busy
// (IDLE or DONE); the operands are captured on that edge. busy is high while
// slices are being added, and done pulses for exactly one cycle when Sum, CO
// and OV have been loaded. start while busy is ignored. Sum, CO and OV hold
// their value between done pulses.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             OV,
    output logic [1:0]       fsm_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operand shift registers: the slice being added is always the low CHUNK bits.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0]       slice_sum;
    logic                   slice_cout;
    logic                   slice_cmsb;
    logic                   last_slice;
    logic                   capture;
    logic [WIDTH+CHUNK-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_next;

    assign last_slice = (cnt == CW'(NCHUNK - 1));
    assign capture    = start && (state != RUN);

    // New slice sums enter at the top of the accumulator and shift down, so
    // after NCHUNK slices the LSB slice has reached bit 0.
    assign acc_cat  = {slice_sum, acc};
    assign acc_next = acc_cat[WIDTH+CHUNK-1:CHUNK];

    // Ripple of CHUNK full-adder cells over the current slice; also keeps the
    // carry into the top cell, which becomes the carry into the MSB on the last slice.
    always_comb begin
        logic c;
        c          = carry;
        slice_sum  = '0;
        slice_cmsb = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) slice_cmsb = c;
            slice_sum[i] = a_reg[i] ^ b_reg[i] ^ c;
            c            = (a_reg[i] & b_reg[i]) | (c & (a_reg[i] ^ b_reg[i]));
        end
        slice_cout = c;
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        fsm_state = state;
    end

    // Operand capture and per-slice datapath update.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
        end else if (capture) begin
            a_reg <= A;
            b_reg <= sub ? ~B : B;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_reg >> CHUNK;
            b_reg <= b_reg >> CHUNK;
            carry <= slice_cout;
            acc   <= acc_next;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers: loaded only on the edge that finishes the last slice.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Sum <= '0;
            CO  <= 1'b0;
            OV  <= 1'b0;
        end else if (state == RUN && last_slice) begin
            Sum <= acc_next;
            CO  <= slice_cout;
            OV  <= slice_cmsb ^ slice_cout;
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Testbench for chunked_adder: default 16/4 build plus CHUNK=16 and CHUNK=1
// builds sharing the same stimulus.
module tb_chunked_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         busy, done, co, ov;
    logic [W-1:0] sum;
    logic [1:0]   st;
    logic         busy16, done16, co16, ov16;
    logic [W-1:0] sum16;
    logic [1:0]   st16;
    logic         busy1, done1, co1, ov1;
    logic [W-1:0] sum1;
    logic [1:0]   st1;

    int n_checks = 0;
    int n_fail   = 0;

    chunked_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .Clk(clk), .Reset_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .A(a), .B(b), .busy(busy), .done(done), .Sum(sum), .CO(co), .OV(ov),
        .fsm_state(st)
    );

    chunked_adder #(.WIDTH(W), .CHUNK(16)) dut16 (
        .Clk(clk), .Reset_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .A(a), .B(b), .busy(busy16), .done(done16), .Sum(sum16), .CO(co16), .OV(ov16),
        .fsm_state(st16)
    );

    chunked_adder #(.WIDTH(W), .CHUNK(1)) dut1 (
        .Clk(clk), .Reset_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .A(a), .B(b), .busy(busy1), .done(done1), .Sum(sum1), .CO(co1), .OV(ov1),
        .fsm_state(st1)
    );

    // Clock.
    always #5 clk = ~clk;

    // Reference model: {OV, CO, Sum} from plain wide arithmetic.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                               input logic s_i, input logic c_i);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ov_m;
        be   = s_i ? ~b_i : b_i;
        full = {1'b0, a_i} + {1'b0, be} + {{W{1'b0}}, (s_i ? 1'b1 : c_i)};
        ov_m = (a_i[W-1] == be[W-1]) && (full[W-1] != a_i[W-1]);
        return {ov_m, full[W], full[W-1:0]};
    endfunction

    // Driver: present operands with start for one edge; returns at the
    // falling edge just after the start edge.
    task automatic launch(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic s_i, input logic c_i);
        @(negedge clk);
        a     = a_i;
        b     = b_i;
        sub   = s_i;
        cin   = c_i;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({busy, done, co, ov, sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_w4: got busy=%b done=%b co=%b ov=%b sum=%h, want all 0", busy, done, co, ov, sum);
        end
        n_checks++;
        if ({busy16, done16, co16, ov16, sum16} !== '0) begin
            n_fail++;
            $display("FAIL reset_w16: got busy=%b done=%b sum=%h, want all 0", busy16, done16, sum16);
        end
        n_checks++;
        if ({busy1, done1, co1, ov1, sum1} !== '0) begin
            n_fail++;
            $display("FAIL reset_w1: got busy=%b done=%b sum=%h, want all 0", busy1, done1, sum1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_busy cycle %0d: got busy=%b done=%b, want busy=1 done=0", k, busy, done);
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b busy=%b 4 cycles after start, want done=1 busy=0", done, busy);
        end
        n_checks++;
        if (sum !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got sum=%h co=%b ov=%b, want 0000 1 0", sum, co, ov);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h0000 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_after: got done=%b busy=%b sum=%h co=%b, want 0 0 0000 1", done, busy, sum, co);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[4] = '{16'h7FFF, 16'h1234, 16'h0005, 16'h8000};
        logic [W-1:0] vb[4] = '{16'h0001, 16'h1111, 16'h0007, 16'h0001};
        logic         vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic         vc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] es[4] = '{16'h8000, 16'h2346, 16'hFFFE, 16'h7FFF};
        logic         eco[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic         eov[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i], vs[i], vc[i]);
            lat = 0;
            while (done !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat != 4) begin
                n_fail++;
                $display("FAIL vector%0d_latency: got %0d cycles, want 4", i, lat);
            end
            n_checks++;
            if (sum !== es[i] || co !== eco[i] || ov !== eov[i]) begin
                n_fail++;
                $display("FAIL vector%0d_result: got sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                         i, sum, co, ov, es[i], eco[i], eov[i]);
            end
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        logic [W+1:0] exp;
        int lat;
        // Previous result (0x7FFF) must hold throughout this run.
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        lat = 0;
        @(negedge clk);
        lat++;
        // Second RUN cycle: pulse start with different operands.
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        sub   = 1'b1;
        n_checks++;
        if (sum !== 16'h7FFF || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_during_run: got sum=%h busy=%b, want 7fff 1", sum, busy);
        end
        @(negedge clk);
        lat++;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'b1;
        n_checks++;
        if (sum !== 16'h7FFF || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_after_ignored_start: got sum=%h busy=%b, want 7fff 1", sum, busy);
        end
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4 || sum !== 16'h3333 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start: got lat=%0d sum=%h co=%b ov=%b, want 4 3333 0 0", lat, sum, co, ov);
        end
        // Start during DONE: back-to-back operation.
        a     = 16'h00F0;
        b     = 16'h0F0F;
        sub   = 1'b0;
        cin   = 1'b1;
        exp   = ref_model(a, b, sub, cin);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_enter_run: got busy=%b done=%b, want 1 0", busy, done);
        end
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4 || {ov, co, sum} !== exp) begin
            n_fail++;
            $display("FAIL b2b_result: got lat=%0d ov/co/sum=%h, want 4 %h", lat, {ov, co, sum}, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        logic seen_done;
        int lat;
        launch(16'h4321, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        // Third RUN cycle, clock low: asynchronous reset.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, co, ov, sum} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b co=%b ov=%b sum=%h, want all 0", busy, done, co, ov, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got done/busy activity after reset, want none");
        end
        launch(16'h0003, 16'h0004, 1'b0, 1'b0);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4 || sum !== 16'h0007 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_op: got lat=%0d sum=%h co=%b ov=%b, want 4 0007 0 0", lat, sum, co, ov);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q[$];
        logic [W+1:0] exp;
        logic [W+1:0] got;
        int lat;
        for (int i = 0; i < 24; i++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exp = ref_model(a, b, sub, cin);
            exp_q.push_back(exp[W-1:0]);
            lat = 0;
            while (done !== 1'b1 && lat < 40) begin
                a   = W'($urandom);
                b   = W'($urandom);
                sub = 1'($urandom_range(0, 1));
                cin = 1'($urandom_range(0, 1));
                @(negedge clk);
                lat++;
            end
            got = {ov, co, sum};
            n_checks++;
            if (lat != 4 || got !== exp || sum !== exp_q.pop_front()) begin
                n_fail++;
                $display("FAIL random%0d: got lat=%0d ov/co/sum=%h, want 4 %h", i, lat, got, exp);
            end
        end
    endtask

    task automatic test_chunk_variants();
        logic [W+1:0] exp;
        logic [W+1:0] res16;
        logic [W+1:0] res1;
        int lat16;
        int lat1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exp   = ref_model(a, b, sub, cin);
            lat16 = -1;
            lat1  = -1;
            res16 = '0;
            res1  = '0;
            for (int cyc = 0; cyc <= 20; cyc++) begin
                if (done16 === 1'b1 && lat16 < 0) begin
                    lat16 = cyc;
                    res16 = {ov16, co16, sum16};
                end
                if (done1 === 1'b1 && lat1 < 0) begin
                    lat1 = cyc;
                    res1 = {ov1, co1, sum1};
                end
                @(negedge clk);
            end
            n_checks++;
            if (lat16 != 1 || res16 !== exp) begin
                n_fail++;
                $display("FAIL chunk16_op%0d: got lat=%0d ov/co/sum=%h, want 1 %h", i, lat16, res16, exp);
            end
            n_checks++;
            if (lat1 != 16 || res1 !== exp) begin
                n_fail++;
                $display("FAIL chunk1_op%0d: got lat=%0d ov/co/sum=%h, want 16 %h", i, lat1, res1, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_and_back_to_back();
        test_reset_mid_run();
        test_random();
        test_chunk_variants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
